// File: rtl/sc_level_pkg.sv
// sc_level_pkg: shared state encoding, wrap-mode constants and width helper for the level tracker.
package sc_level_pkg;
   localparam logic [1:0] ST_PLAY = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int WRAP_SATURATE = 0;
   localparam int WRAP_CYCLE = 1;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/sc_hold_timer.sv
// sc_hold_timer: loadable down counter that stops at zero and flags expiry.
module sc_hold_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (load) cnt <= value;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign expired = cnt == '0;
endmodule

// File: rtl/sc_level_tracker.sv
// sc_level_tracker: counts levels won, one per qualified win, with post-win hold-off,
// level-up pulse and sticky game-complete flag.
module sc_level_tracker
   import sc_level_pkg::*;
#(
   parameter int LEVEL_W        = 3,
   parameter int ENTRY_W        = 2,
   parameter int ENTRIES_TO_WIN = 3,
   parameter int LEVEL_MIN      = 1,
   parameter int LEVEL_MAX      = 7,
   parameter int WRAP_MODE      = 0,
   parameter int HOLD_CYCLES    = 4
) (
   input  logic               SC_RegLEVEL_CLOCK_50,
   input  logic               SC_RegLEVEL_RESET_InHigh,
   input  logic               SC_RegLEVEL_clear_InHigh,
   input  logic               SC_RegLEVEL_chgEntry_InLow,
   input  logic [ENTRY_W-1:0] SC_RegLEVEL_numEntry_In,
   output logic [LEVEL_W-1:0] SC_RegLEVEL_numLevel_Out,
   output logic               SC_RegLEVEL_levelUp_Out,
   output logic               SC_RegLEVEL_busy_Out,
   output logic               SC_RegLEVEL_gameDone_Out
);
   localparam int CNT_W = clog2(HOLD_CYCLES + 1);
   logic [1:0] state, state_nx;
   logic [LEVEL_W-1:0] level, level_nx;
   logic level_up, level_up_nx, win, at_max, load, expired;
   assign win = !SC_RegLEVEL_chgEntry_InLow && SC_RegLEVEL_numEntry_In == ENTRY_W'(ENTRIES_TO_WIN);
   assign at_max = level == LEVEL_W'(LEVEL_MAX);
   sc_hold_timer #(.W(CNT_W)) u_hold (
      .clk     (SC_RegLEVEL_CLOCK_50),
      .rst     (SC_RegLEVEL_RESET_InHigh),
      .clr     (SC_RegLEVEL_clear_InHigh),
      .load    (load),
      .value   (CNT_W'(HOLD_CYCLES)),
      .expired (expired)
   );
   // HOLD leaves only once the timer is spent and the win has been released, so a held win counts once.
   always_comb begin
      state_nx = state;
      level_nx = level;
      level_up_nx = 1'b0;
      load = 1'b0;
      if (state == ST_PLAY && win) begin
         if (!at_max || WRAP_MODE == WRAP_CYCLE) begin
            level_nx = at_max ? LEVEL_W'(LEVEL_MIN) : level + LEVEL_W'(1);
            level_up_nx = 1'b1;
            load = 1'b1;
            state_nx = ST_HOLD;
         end else state_nx = ST_DONE;
      end else if (state == ST_HOLD) state_nx = (expired && !win) ? ST_PLAY : ST_HOLD;
      else if (state != ST_PLAY && state != ST_DONE) state_nx = ST_PLAY;
   end
   always_ff @(posedge SC_RegLEVEL_CLOCK_50 or posedge SC_RegLEVEL_RESET_InHigh)
      if (SC_RegLEVEL_RESET_InHigh || SC_RegLEVEL_clear_InHigh) begin
         state <= ST_PLAY;
         level <= LEVEL_W'(LEVEL_MIN);
         level_up <= 1'b0;
      end else begin
         state <= state_nx;
         level <= level_nx;
         level_up <= level_up_nx;
      end
   assign SC_RegLEVEL_numLevel_Out = level;
   assign SC_RegLEVEL_levelUp_Out = level_up;
   assign SC_RegLEVEL_busy_Out = state == ST_HOLD;
   assign SC_RegLEVEL_gameDone_Out = state == ST_DONE;
endmodule

// File: tb/tb_sc_level_tracker.sv
// tb_sc_level_tracker: vector table, directed corner sequences and random play against a
// behavioural model, driving a saturating and a wrapping instance with the same inputs.
module tb_sc_level_tracker;
   localparam int LMIN = 1, LMAX = 7, HOLD = 4;
   typedef struct {
      int level;
      int phase;
      int left;
      bit up;
   } mdl_t;
   typedef struct {
      bit clr;
      bit chg_n;
      logic [1:0] num;
      int level;
      bit up;
      bit busy;
      bit done;
   } vec_t;
   logic clk = 0, rst = 1, clr = 0, chg_n = 1;
   logic [1:0] num = '0;
   logic [2:0] lvl0, lvl1;
   logic up0, up1, busy0, busy1, done0, done1;
   int passed = 0, total = 0;
   mdl_t m0, m1;
   vec_t tbl[11];
   always #5 clk = ~clk;
   sc_level_tracker dut (
      .SC_RegLEVEL_CLOCK_50(clk), .SC_RegLEVEL_RESET_InHigh(rst), .SC_RegLEVEL_clear_InHigh(clr),
      .SC_RegLEVEL_chgEntry_InLow(chg_n), .SC_RegLEVEL_numEntry_In(num),
      .SC_RegLEVEL_numLevel_Out(lvl0), .SC_RegLEVEL_levelUp_Out(up0),
      .SC_RegLEVEL_busy_Out(busy0), .SC_RegLEVEL_gameDone_Out(done0)
   );
   sc_level_tracker #(.WRAP_MODE(1)) dut_w (
      .SC_RegLEVEL_CLOCK_50(clk), .SC_RegLEVEL_RESET_InHigh(rst), .SC_RegLEVEL_clear_InHigh(clr),
      .SC_RegLEVEL_chgEntry_InLow(chg_n), .SC_RegLEVEL_numEntry_In(num),
      .SC_RegLEVEL_numLevel_Out(lvl1), .SC_RegLEVEL_levelUp_Out(up1),
      .SC_RegLEVEL_busy_Out(busy1), .SC_RegLEVEL_gameDone_Out(done1)
   );
   function automatic mdl_t fresh();
      mdl_t m;
      m.level = LMIN;
      m.phase = 0;
      m.left = 0;
      m.up = 0;
      return m;
   endfunction
   // phase: 0 playing, 1 holding off after a level-up, 2 game over
   function automatic mdl_t step(mdl_t m, bit c, bit w, bit wrap);
      mdl_t n = m;
      n.up = 0;
      if (c) return fresh();
      if (m.phase == 0 && w) begin
         if (m.level < LMAX || wrap) begin
            n.level = m.level < LMAX ? m.level + 1 : LMIN;
            n.up = 1;
            n.left = HOLD;
            n.phase = 1;
         end else n.phase = 2;
      end else if (m.phase == 1) begin
         if (m.left == 0 && !w) n.phase = 0;
         n.left = m.left > 0 ? m.left - 1 : 0;
      end
      return n;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask
   task automatic cmp_model();
      check("mdl_level", lvl0, m0.level);
      check("mdl_up", up0, m0.up);
      check("mdl_busy", busy0, m0.phase == 1);
      check("mdl_done", done0, m0.phase == 2);
      check("mdlw_level", lvl1, m1.level);
      check("mdlw_up", up1, m1.up);
      check("mdlw_busy", busy1, m1.phase == 1);
      check("mdlw_done", done1, m1.phase == 2);
   endtask
   task automatic tick(input bit c, input bit n, input logic [1:0] e);
      bit w;
      clr = c;
      chg_n = n;
      num = e;
      w = !n && e == 2'd3;
      @(posedge clk);
      m0 = step(m0, c, w, 0);
      m1 = step(m1, c, w, 1);
      #1;
      cmp_model();
   endtask
   task automatic win_then_rest();
      tick(0, 0, 3);
      repeat (HOLD + 1) tick(0, 1, 0);
   endtask
   initial begin
      int ups, lvl;
      tbl = '{
         '{0, 0, 3, 2, 1, 1, 0}, '{0, 1, 3, 2, 0, 1, 0}, '{0, 1, 0, 2, 0, 1, 0},
         '{0, 1, 0, 2, 0, 1, 0}, '{0, 1, 0, 2, 0, 1, 0}, '{0, 1, 0, 2, 0, 0, 0},
         '{0, 0, 2, 2, 0, 0, 0}, '{0, 1, 3, 2, 0, 0, 0}, '{0, 0, 3, 3, 1, 1, 0},
         '{1, 0, 3, 1, 0, 0, 0}, '{0, 0, 3, 2, 1, 1, 0}
      };
      m0 = fresh();
      m1 = fresh();
      repeat (2) @(posedge clk);
      #1;
      check("rst_level", lvl0, LMIN);
      check("rst_up", up0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      rst = 0;
      for (int i = 0; i < 11; i++) begin
         tick(tbl[i].clr, tbl[i].chg_n, tbl[i].num);
         check($sformatf("vec%0d_level", i), lvl0, tbl[i].level);
         check($sformatf("vec%0d_up", i), up0, tbl[i].up);
         check($sformatf("vec%0d_busy", i), busy0, tbl[i].busy);
         check($sformatf("vec%0d_done", i), done0, tbl[i].done);
      end
      // asynchronous reset in the middle of a hold-off
      #3;
      rst = 1;
      #1;
      m0 = fresh();
      m1 = fresh();
      check("arst_level", lvl0, LMIN);
      check("arst_up", up0, 0);
      check("arst_busy", busy0, 0);
      check("arstw_level", lvl1, LMIN);
      #2;
      rst = 0;
      win_then_rest();
      check("single_level", lvl0, 2);
      ups = 0;
      for (int i = 0; i < 20; i++) begin
         tick(0, 0, 3);
         ups += up0;
      end
      check("held_ups", ups, 1);
      check("held_level", lvl0, 3);
      check("held_busy", busy0, 1);
      repeat (HOLD) tick(0, 1, 3);
      check("held_release_busy", busy0, 0);
      tick(1, 1, 0);
      for (int i = 0; i < 6; i++) win_then_rest();
      check("sat_level", lvl0, LMAX);
      check("satw_level", lvl1, LMAX);
      tick(0, 0, 3);
      check("sat_done", done0, 1);
      check("sat_level7", lvl0, LMAX);
      check("sat_no_up", up0, 0);
      check("wrap_level", lvl1, LMIN);
      check("wrap_up", up1, 1);
      check("wrap_done", done1, 0);
      tick(0, 1, 0);
      check("sat_sticky", done0, 1);
      tick(1, 0, 3);
      check("clr_done_level", lvl0, LMIN);
      check("clr_done_flag", done0, 0);
      check("clr_done_up", up0, 0);
      check("clr_hold_busy", busy1, 0);
      check("clr_hold_up", up1, 0);
      for (int i = 0; i < 3000; i++) begin
         lvl = $urandom_range(0, 3);
         tick($urandom_range(0, 63) == 0, $urandom_range(0, 1), 2'(lvl));
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
